// File: rtl/iobuf_bank_ctrl.sv
// Multi-channel sequencer for 74LVC1T45 / 74LVC1G07 IO buffer pairs: every mode change passes
// through a Hi-Z dead-time so FPGA pad, 1T45 and 1G07 never drive against each other.
module iobuf_bank_ctrl #(
   parameter int CHANNELS    = 8,
   parameter int DEADTIME    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                hiz_all,
   input  logic [CHANNELS-1:0] oe,
   input  logic [CHANNELS-1:0] od,
   input  logic [CHANNELS-1:0] dir,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] dout,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] bufdir,
   output logic [CHANNELS-1:0] bufod,
   output logic [CHANNELS-1:0] bufdat_tristate_oe,
   output logic [CHANNELS-1:0] bufdat_tristate_dout,
   input  logic [CHANNELS-1:0] bufdat_tristate_din
);

   localparam int CW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEADTIME - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEAD,
      S_ARM,
      S_PP,
      S_EXIT,
      S_OD
   } state_t;

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          req_in, req_od;
      logic          dir_q, od_q, oe_q, busy_q, dat_q;

      always_comb begin
         req_in  = hiz_all | ~oe[ch] | ~dir[ch];
         req_od  = ~req_in & od[ch];
         state_d = state_q;
         cnt_d   = cnt_q;
         unique case (state_q)
            S_IDLE: begin
               if (!req_in) begin
                  state_d = S_DEAD;
                  cnt_d   = CNT_LOAD;
               end
            end
            S_DEAD: begin
               // Request is only looked at when the dead-time expires
               if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
               else if (req_in)  state_d = S_IDLE;
               else if (req_od)  state_d = S_OD;
               else              state_d = S_ARM;
            end
            S_ARM:  state_d = S_PP;
            S_PP: begin
               if (req_in || req_od) state_d = S_EXIT;
            end
            S_EXIT: begin
               if (req_in) state_d = S_IDLE;
               else begin
                  state_d = S_DEAD;
                  cnt_d   = CNT_LOAD;
               end
            end
            S_OD: begin
               if (req_in) state_d = S_IDLE;
               else if (!req_od) begin
                  state_d = S_DEAD;
                  cnt_d   = CNT_LOAD;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Pin outputs are registered from the next state so they change on the same edge as the FSM
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            od_q    <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            dat_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= (state_d == S_ARM) || (state_d == S_PP) || (state_d == S_EXIT);
            od_q    <= (state_d == S_OD) ? din[ch] : 1'b1;
            oe_q    <= (state_d == S_PP);
            busy_q  <= (state_d == S_DEAD) || (state_d == S_ARM) || (state_d == S_EXIT);
            dat_q   <= din[ch];
         end
      end

      assign bufdir[ch]               = dir_q;
      assign bufod[ch]                = od_q;
      assign bufdat_tristate_oe[ch]   = oe_q;
      assign busy[ch]                 = busy_q;
      assign bufdat_tristate_dout[ch] = dat_q;
   end

   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= bufdat_tristate_din;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_iobuf_bank_ctrl.sv
// Randomised bench for iobuf_bank_ctrl: per-channel timeline model of Hi-Z dead-time sequencing,
// pin invariants and read-back synchroniser latency.
module tb_iobuf_bank_ctrl;
   localparam int CH = 8;
   localparam int DT = 4;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          hiz_all;
   logic [CH-1:0] oe, od, dir, din, pad;
   logic [CH-1:0] dout, busy, bufdir, bufod, t_oe, t_dout;

   iobuf_bank_ctrl #(.CHANNELS(CH), .DEADTIME(DT), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n), .hiz_all(hiz_all), .oe(oe), .od(od), .dir(dir), .din(din),
      .dout(dout), .busy(busy), .bufdir(bufdir), .bufod(bufod),
      .bufdat_tristate_oe(t_oe), .bufdat_tristate_dout(t_dout), .bufdat_tristate_din(pad)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: each channel is a timeline of Hi-Z cycles left, a one-cycle arm/release step
   // and what is being driven (0 none, 1 open-drain, 2 push-pull).
   int            hiz_left [CH];
   bit            arming   [CH];
   bit            releasing[CH];
   int            drive    [CH];
   logic [CH-1:0] e_dir, e_od, e_oe, e_busy, e_dat, e_dout;
   logic [CH-1:0] hist[$];
   logic [CH-1:0] prev_dir;

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         hiz_left[c] = 0; arming[c] = 0; releasing[c] = 0; drive[c] = 0;
      end
      e_dir = '0; e_od = '1; e_oe = '0; e_busy = '0; e_dat = '0; e_dout = '0;
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back('0);
      prev_dir = '0;
   endtask

   task automatic model_step();
      for (int c = 0; c < CH; c++) begin
         int req;
         req = (hiz_all || !oe[c] || !dir[c]) ? 0 : (od[c] ? 1 : 2);
         if (releasing[c]) begin
            releasing[c] = 0;
            if (req != 0) hiz_left[c] = DT;
         end else if (arming[c]) begin
            arming[c] = 0;
            drive[c]  = 2;
         end else if (hiz_left[c] > 0) begin
            if (hiz_left[c] > 1) hiz_left[c]--;
            else begin
               hiz_left[c] = 0;
               if (req == 1) drive[c] = 1;
               else if (req == 2) arming[c] = 1;
            end
         end else if (drive[c] == 2) begin
            if (req != 2) begin drive[c] = 0; releasing[c] = 1; end
         end else if (drive[c] == 1) begin
            if (req == 0) drive[c] = 0;
            else if (req == 2) begin drive[c] = 0; hiz_left[c] = DT; end
         end else if (req != 0) begin
            hiz_left[c] = DT;
         end
         e_dir[c]  = arming[c] || releasing[c] || drive[c] == 2;
         e_oe[c]   = (drive[c] == 2);
         e_od[c]   = (drive[c] == 1) ? din[c] : 1'b1;
         e_busy[c] = (hiz_left[c] > 0) || arming[c] || releasing[c];
      end
      e_dat = din;
      hist.push_front(pad);
      void'(hist.pop_back());
      e_dout = hist[SS-1];
   endtask

   task automatic do_cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_eq("bufdir", 32'(bufdir), 32'(e_dir));
      check_eq("bufod", 32'(bufod), 32'(e_od));
      check_eq("tristate_oe", 32'(t_oe), 32'(e_oe));
      check_eq("busy", 32'(busy), 32'(e_busy));
      check_eq("tristate_dout", 32'(t_dout), 32'(e_dat));
      check_eq("dout", 32'(dout), 32'(e_dout));
      check_eq("inv_oe_dir", 32'(t_oe & ~(bufdir & prev_dir)), 32'd0);
      check_eq("inv_od_dir", 32'(~bufod & bufdir), 32'd0);
      prev_dir = bufdir;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; hiz_all = 1'b0;
      oe = '0; od = '0; dir = '0; din = '0; pad = '0;
      model_reset();
      #23;
      check_eq("rst_bufdir", 32'(bufdir), 32'd0);
      check_eq("rst_bufod", 32'(bufod), 32'hFF);
      check_eq("rst_oe", 32'(t_oe), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_dout", 32'(dout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ch0 IN -> PP with pad looped back
      oe[0] = 1; dir[0] = 1; din[0] = 1; pad = din;
      for (int i = 1; i <= 8; i++) begin
         do_cycle();
         if (i == 4) check_eq("ch0_dir_e4", 32'(bufdir[0]), 32'd0);
         if (i == 5) check_eq("ch0_dir_e5", 32'(bufdir[0]), 32'd1);
         if (i == 5) check_eq("ch0_oe_e5", 32'(t_oe[0]), 32'd0);
         if (i == 6) check_eq("ch0_oe_e6", 32'(t_oe[0]), 32'd1);
         if (i == 8) check_eq("ch0_busy_e8", 32'(busy[0]), 32'd0);
         if (i == 8) check_eq("ch0_dout_e8", 32'(dout[0]), 32'd1);
      end

      // ch1 PP -> OD pulling low
      oe[1] = 1; dir[1] = 1; din[1] = 1; pad = din;
      for (int i = 0; i < 8; i++) do_cycle();
      od[1] = 1; din[1] = 0; pad = din;
      for (int i = 1; i <= 7; i++) begin
         do_cycle();
         if (i == 1) check_eq("ch1_exit_dir", 32'(bufdir[1]), 32'd1);
         if (i == 5) check_eq("ch1_od_e5", 32'(bufod[1]), 32'd1);
         if (i == 6) check_eq("ch1_od_e6", 32'(bufod[1]), 32'd0);
         if (i >= 6) check_eq("ch1_od_dir", 32'(bufdir[1]), 32'd0);
      end

      // ch2 request wobbles during DEAD; expiry samples PP
      oe[2] = 1; dir[2] = 1; din[2] = 1;
      do_cycle(); do_cycle();
      dir[2] = 0; do_cycle();
      dir[2] = 1;
      for (int i = 0; i < 7; i++) do_cycle();
      check_eq("ch2_pp", 32'(t_oe[2]), 32'd1);

      // all PP, one-cycle hiz_all pulse
      oe = '1; dir = '1; od = '0;
      for (int i = 0; i < 9; i++) do_cycle();
      check_eq("all_pp", 32'(t_oe), 32'hFF);
      hiz_all = 1'b1; do_cycle();
      check_eq("hiz_exit_oe", 32'(t_oe), 32'd0);
      check_eq("hiz_exit_dir", 32'(bufdir), 32'hFF);
      hiz_all = 1'b0;
      for (int i = 0; i < 7; i++) do_cycle();
      check_eq("hiz_back_pp", 32'(t_oe), 32'hFF);

      // async reset in the middle of PP
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      check_eq("arst_oe", 32'(t_oe), 32'd0);
      check_eq("arst_dir", 32'(bufdir), 32'd0);
      check_eq("arst_od", 32'(bufod), 32'hFF);
      check_eq("arst_busy", 32'(busy), 32'd0);
      model_reset();
      oe = '0; dir = '0; od = '0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 10000; n++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 7) == 0) oe[c]  = ~oe[c];
            if ($urandom_range(0, 7) == 0) dir[c] = ~dir[c];
            if ($urandom_range(0, 9) == 0) od[c]  = ~od[c];
         end
         hiz_all = ($urandom_range(0, 63) == 0);
         din = CH'($urandom);
         pad = CH'($urandom);
         do_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
